tx_vc_arbiter: RTL and testbench



---
 rtl/tx_pkg.sv | 21 ++
 rtl/tx_credit_cnt.sv | 67 ++++++
 rtl/tx_vc_arbiter.sv | 179 +++++++++++++++++
 tb/tb_tx_vc_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared encodings and defaults for the transmit VC arbiter
//
// Contents:
//   tx_state_t - arbiter state encoding (RESET=0, INIT=1, IDLE=2, ACTIVE=3)
//   DEST_BIT   - bit of a VC word that selects D0 (0) or D1 (1)
//   DW_DEF, TW_DEF, DEPTH_DEF - default data, threshold and D-FIFO sizes
package tx_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } tx_state_t;

  localparam int DEST_BIT  = 4;
  localparam int DW_DEF    = 6;
  localparam int TW_DEF    = 5;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/tx_credit_cnt.sv
// rtl/tx_credit_cnt.sv - occupancy counter for one output FIFO with flags
//
// Ports:
//   clk, RESET_L   clock, asynchronous active-low reset
//   flag_en        high in IDLE/ACTIVE; otherwise flags read af=0 / ae=1
//   inc            a word was granted towards this FIFO this cycle
//   dec            external pop of this FIFO this cycle
//   low, high      latched thresholds
//   can_accept     count below both high and DEPTH, so a grant may proceed
//   almost_full    count >= high
//   almost_empty   count <= low
//   err            sticky: a pop arrived while the FIFO was empty
module tx_credit_cnt #(
  parameter int TW    = 5,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          RESET_L,
  input  logic          flag_en,
  input  logic          inc,
  input  logic          dec,
  input  logic [TW-1:0] low,
  input  logic [TW-1:0] high,
  output logic          can_accept,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          err
);

  localparam int CW = $clog2(DEPTH + 1);
  // Compare in a width that holds both the count and any threshold value.
  localparam int XW = ((TW > CW) ? TW : CW) + 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);

  logic [CW-1:0] cnt;
  logic [XW-1:0] cnt_x, low_x, high_x;
  logic          inc_ok, dec_ok;

  assign cnt_x  = XW'(cnt);
  assign low_x  = XW'(low);
  assign high_x = XW'(high);

  // A pop of an empty FIFO is dropped; it only raises err.
  assign inc_ok = inc && (cnt_x < DEPTH_X);
  assign dec_ok = dec && (cnt != '0);

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (inc_ok && !dec_ok) begin
        cnt <= cnt + CW'(1);
      end else if (!inc_ok && dec_ok) begin
        cnt <= cnt - CW'(1);
      end
      if (dec && (cnt == '0)) begin
        err <= 1'b1;
      end
    end
  end

  assign can_accept   = (cnt_x < high_x) && (cnt_x < DEPTH_X);
  assign almost_full  = flag_en && (cnt_x >= high_x);
  assign almost_empty = !flag_en || (cnt_x <= low_x);

endmodule

// File: rtl/tx_vc_arbiter.sv
// rtl/tx_vc_arbiter.sv - schedules VC0/VC1 head words into output FIFOs D0/D1
//
// Optional build macro TX_VC_RR_EN: round-robin between VCs when both are
// eligible; without it VC0 has strict priority. Ports are identical.
//
// Ports:
//   clk, RESET_L                clock, asynchronous active-low reset
//   init                        hold high to enter INIT and latch thresholds
//   vc0_data/vc1_data           show-ahead VC head words; bit DEST_BIT = dest
//   vc0_empty/vc1_empty         VC FIFO empty
//   POP_D0/POP_D1               external pops of D0/D1
//   Do_low/Do_high/D1_low/D1_high  occupancy thresholds
//   vc0_pop/vc1_pop             combinational VC pops (one-hot or none)
//   d0_push/d1_push, d0_data/d1_data  registered pushes into D0/D1
//   d*_almost_full/empty        occupancy flags
//   idle, state, err            status; err is sticky underflow
module tx_vc_arbiter
  import tx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TW    = TW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          RESET_L,
  input  logic          init,
  input  logic [DW-1:0] vc0_data,
  input  logic [DW-1:0] vc1_data,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic          POP_D0,
  input  logic          POP_D1,
  input  logic [TW-1:0] Do_low,
  input  logic [TW-1:0] Do_high,
  input  logic [TW-1:0] D1_low,
  input  logic [TW-1:0] D1_high,
  output logic          vc0_pop,
  output logic          vc1_pop,
  output logic          d0_push,
  output logic          d1_push,
  output logic [DW-1:0] d0_data,
  output logic [DW-1:0] d1_data,
  output logic          d0_almost_full,
  output logic          d1_almost_full,
  output logic          d0_almost_empty,
  output logic          d1_almost_empty,
  output logic          idle,
  output logic [1:0]    state,
  output logic          err
);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] d0_low_q, d0_high_q, d1_low_q, d1_high_q;
  logic [1:0]    can_accept;
  logic          vc0_dest, vc1_dest, vc0_elig, vc1_elig;
  logic          grant, grant_dest, inc0, inc1, flag_en, err0, err1;
  logic [DW-1:0] grant_data;

  assign vc0_dest = vc0_data[DEST_BIT];
  assign vc1_dest = vc1_data[DEST_BIT];
  assign vc0_elig = (state_q == ST_ACTIVE) && !vc0_empty && can_accept[vc0_dest];
  assign vc1_elig = (state_q == ST_ACTIVE) && !vc1_empty && can_accept[vc1_dest];

`ifdef TX_VC_RR_EN
  // last_vc1 = 1 when VC1 took the most recent grant; VC0 goes first after reset.
  logic last_vc1;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      last_vc1 <= 1'b1;
    end else if (vc0_pop) begin
      last_vc1 <= 1'b0;
    end else if (vc1_pop) begin
      last_vc1 <= 1'b1;
    end
  end

  assign vc0_pop = vc0_elig && (!vc1_elig || last_vc1);
  assign vc1_pop = vc1_elig && !vc0_pop;
`else
  assign vc0_pop = vc0_elig;
  assign vc1_pop = vc1_elig && !vc0_elig;
`endif

  assign grant      = vc0_pop || vc1_pop;
  assign grant_data = vc0_pop ? vc0_data : vc1_data;
  assign grant_dest = vc0_pop ? vc0_dest : vc1_dest;
  assign inc0       = grant && !grant_dest;
  assign inc1       = grant && grant_dest;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      d0_push <= 1'b0;
      d1_push <= 1'b0;
      d0_data <= '0;
      d1_data <= '0;
    end else begin
      d0_push <= inc0;
      d1_push <= inc1;
      if (inc0) d0_data <= grant_data;
      if (inc1) d1_data <= grant_data;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      d0_low_q  <= '0;
      d0_high_q <= '0;
      d1_low_q  <= '0;
      d1_high_q <= '0;
    end else if (state_q == ST_INIT) begin
      d0_low_q  <= Do_low;
      d0_high_q <= Do_high;
      d1_low_q  <= D1_low;
      d1_high_q <= D1_high;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init) state_d = ST_INIT;
        else if (!vc0_empty || !vc1_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Stay ACTIVE while a granted word is still being pushed.
        if (init) state_d = ST_INIT;
        else if (vc0_empty && vc1_empty && !d0_push && !d1_push) state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign flag_en = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

  tx_credit_cnt #(.TW(TW), .DEPTH(DEPTH)) u_cnt_d0 (
    .clk          (clk),
    .RESET_L      (RESET_L),
    .flag_en      (flag_en),
    .inc          (inc0),
    .dec          (POP_D0),
    .low          (d0_low_q),
    .high         (d0_high_q),
    .can_accept   (can_accept[0]),
    .almost_full  (d0_almost_full),
    .almost_empty (d0_almost_empty),
    .err          (err0)
  );

  tx_credit_cnt #(.TW(TW), .DEPTH(DEPTH)) u_cnt_d1 (
    .clk          (clk),
    .RESET_L      (RESET_L),
    .flag_en      (flag_en),
    .inc          (inc1),
    .dec          (POP_D1),
    .low          (d1_low_q),
    .high         (d1_high_q),
    .can_accept   (can_accept[1]),
    .almost_full  (d1_almost_full),
    .almost_empty (d1_almost_empty),
    .err          (err1)
  );

  assign state = state_q;
  assign idle  = (state_q == ST_IDLE);
  assign err   = err0 || err1;

endmodule

// File: tb/tb_tx_vc_arbiter.sv
// tb/tb_tx_vc_arbiter.sv - randomized scoreboard bench for tx_vc_arbiter
module tb_tx_vc_arbiter;

  logic       clk = 1'b0;
  logic       RESET_L, init, vc0_empty, vc1_empty, POP_D0, POP_D1;
  logic [5:0] vc0_data, vc1_data, d0_data, d1_data;
  logic [4:0] Do_low, Do_high, D1_low, D1_high;
  logic       vc0_pop, vc1_pop, d0_push, d1_push;
  logic       d0_almost_full, d1_almost_full, d0_almost_empty, d1_almost_empty;
  logic       idle, err;
  logic [1:0] state;

  always #5 clk = ~clk;

  tx_vc_arbiter dut (
    .clk(clk), .RESET_L(RESET_L), .init(init),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .POP_D0(POP_D0), .POP_D1(POP_D1),
    .Do_low(Do_low), .Do_high(Do_high), .D1_low(D1_low), .D1_high(D1_high),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_push(d0_push), .d1_push(d1_push),
    .d0_data(d0_data), .d1_data(d1_data),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .d0_almost_empty(d0_almost_empty), .d1_almost_empty(d1_almost_empty),
    .idle(idle), .state(state), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // VC FIFO contents presented to the DUT and expected D0/D1 pushes.
  logic [5:0] q0[$], q1[$], exp0[$], exp1[$];

  // Stimulus applied on the next cycle.
  bit rst_v, init_v, p0_v, p1_v;
  int lo_v[2], hi_v[2];

  // Reference model: architectural view of the arbiter.
  int m_state, m_cnt[2], m_lo[2], m_hi[2];
  bit m_err, m_push_pend, m_last1;

  // DUT values sampled in the last cycle.
  bit obs_pop0, obs_pop1, obs_af0, obs_ae0, obs_err;
  int obs_state;

  function automatic void check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_err = 0;
    m_push_pend = 0;
    m_last1 = 1;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_lo[d] = 0; m_hi[d] = 0;
    end
    exp0.delete();
    exp1.delete();
  endfunction

  function automatic bit room(int d);
    int lim;
    lim = (m_hi[d] < 8) ? m_hi[d] : 8;
    return m_cnt[d] < lim;
  endfunction

  function automatic void model_step(bit g0, bit g1);
    int inc[2];
    int dec;
    bit pops[2];
    bit any_vc;
    logic [5:0] w;
    inc[0] = 0; inc[1] = 0;
    pops[0] = p0_v; pops[1] = p1_v;
    any_vc = (q0.size() != 0) || (q1.size() != 0);
    if (g0) begin
      w = q0.pop_front();
      inc[w[4]] = 1;
      if (w[4]) exp1.push_back(w); else exp0.push_back(w);
    end
    if (g1) begin
      w = q1.pop_front();
      inc[w[4]] = 1;
      if (w[4]) exp1.push_back(w); else exp0.push_back(w);
    end
    for (int d = 0; d < 2; d++) begin
      dec = 0;
      if (pops[d]) begin
        if (m_cnt[d] == 0) m_err = 1; else dec = 1;
      end
      m_cnt[d] = m_cnt[d] + inc[d] - dec;
    end
    case (m_state)
      0: m_state = 1;
      1: begin
        for (int d = 0; d < 2; d++) begin
          m_lo[d] = lo_v[d]; m_hi[d] = hi_v[d];
        end
        if (!init_v) m_state = 2;
      end
      2: if (init_v) m_state = 1; else if (any_vc) m_state = 3;
      default: if (init_v) m_state = 1; else if (!any_vc && !m_push_pend) m_state = 2;
    endcase
    m_push_pend = g0 || g1;
    if (g0) m_last1 = 0; else if (g1) m_last1 = 1;
  endfunction

  task automatic cycle();
    bit e0, e1, g0, g1;
    bit act;
    @(negedge clk);
    RESET_L = rst_v; init = init_v; POP_D0 = p0_v; POP_D1 = p1_v;
    Do_low = 5'(lo_v[0]); Do_high = 5'(hi_v[0]);
    D1_low = 5'(lo_v[1]); D1_high = 5'(hi_v[1]);
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data = (q0.size() != 0) ? q0[0] : 6'd0;
    vc1_data = (q1.size() != 0) ? q1[0] : 6'd0;
    if (!rst_v) model_reset();
    #1;
    e0 = (m_state == 3) && (q0.size() != 0) && room(int'(q0[0][4]));
    e1 = (m_state == 3) && (q1.size() != 0) && room(int'(q1[0][4]));
`ifdef TX_VC_RR_EN
    if (e0 && e1) begin g0 = m_last1; g1 = !m_last1; end
    else begin g0 = e0; g1 = e1; end
`else
    g0 = e0; g1 = e1 && !e0;
`endif
    act = (m_state >= 2);
    check("vc0_pop", vc0_pop, g0);
    check("vc1_pop", vc1_pop, g1);
    check("state", state, m_state);
    check("idle", idle, m_state == 2);
    check("d0_af", d0_almost_full, act && (m_cnt[0] >= m_hi[0]));
    check("d1_af", d1_almost_full, act && (m_cnt[1] >= m_hi[1]));
    check("d0_ae", d0_almost_empty, !act || (m_cnt[0] <= m_lo[0]));
    check("d1_ae", d1_almost_empty, !act || (m_cnt[1] <= m_lo[1]));
    check("err", err, m_err);
    obs_pop0 = vc0_pop; obs_pop1 = vc1_pop; obs_state = int'(state);
    obs_af0 = d0_almost_full; obs_ae0 = d0_almost_empty; obs_err = err;
    @(posedge clk);
    if (rst_v) model_step(g0, g1);
  endtask

  task automatic run(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (n) begin
      cycle();
      c0 += int'(obs_pop0);
      c1 += int'(obs_pop1);
    end
  endtask

  // Scoreboard monitor: every registered push must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (d0_push) begin
        if (exp0.size() == 0) check("d0_push_unexpected", 1, 0);
        else check("d0_data", d0_data, exp0.pop_front());
      end else if (exp0.size() != 0) begin
        check("d0_push_missing", 0, 1);
        exp0.delete();
      end
      if (d1_push) begin
        if (exp1.size() == 0) check("d1_push_unexpected", 1, 0);
        else check("d1_data", d1_data, exp1.pop_front());
      end else if (exp1.size() != 0) begin
        check("d1_push_missing", 0, 1);
        exp1.delete();
      end
    end
  end

  task automatic do_init(input int lo0, input int hi0, input int lo1, input int hi1);
    int c0, c1;
    rst_v = 0; init_v = 0; p0_v = 0; p1_v = 0;
    q0.delete(); q1.delete();
    run(2, c0, c1);
    check("reset_state", obs_state, 0);
    check("reset_ae0", obs_ae0, 1);
    rst_v = 1; init_v = 1;
    lo_v[0] = lo0; hi_v[0] = hi0; lo_v[1] = lo1; hi_v[1] = hi1;
    run(2, c0, c1);
    check("init_state", obs_state, 1);
    check("init_af0", obs_af0, 0);
    init_v = 0;
    run(2, c0, c1);
    check("idle_after_init", obs_state, 2);
  endtask

  int c0, c1;
  int seq[$];
  int exp_seq[8];

  initial begin
    model_reset();
    rst_v = 0; init_v = 0; p0_v = 0; p1_v = 0;
    lo_v[0] = 0; hi_v[0] = 0; lo_v[1] = 0; hi_v[1] = 0;

    do_init(1, 3, 1, 3);

    // Single word to D0.
    q0.push_back(6'b001010);
    run(4, c0, c1);
    check("single_grants", c0, 1);
    check("single_ae0", obs_ae0, 1);

    // Back-pressure at high=3, then one pop frees exactly one slot.
    p0_v = 1; run(1, c0, c1); p0_v = 0;
    repeat (5) q0.push_back(6'($urandom_range(0, 63)) & 6'h2F);
    run(8, c0, c1);
    check("bp_grants", c0, 3);
    check("bp_af0", obs_af0, 1);
    p0_v = 1; run(1, c0, c1); p0_v = 0;
    check("bp_pop_cycle_grants", c0, 0);
    run(5, c0, c1);
    check("bp_after_pop_grants", c0, 1);

    // VC1 bypasses the blocked VC0 head.
    q1.push_back(6'b010101);
    run(3, c0, c1);
    check("bypass_vc1", c1, 1);
    check("bypass_vc0", c0, 0);

    // Underflow on D1: first pop is real, second is on an empty FIFO.
    p1_v = 1; run(2, c0, c1); p1_v = 0;
    run(1, c0, c1);
    check("underflow_err", obs_err, 1);

    // Grant and pop of D0 in the same cycle leave the count unchanged.
    p0_v = 1; run(1, c0, c1);
    p0_v = 0; run(1, c0, c1);
    q0.push_back(6'b000111);
    p0_v = 1; run(1, c0, c1);
    run(1, c0, c1);
    check("simul_grant", c0, 1);
    p0_v = 0; run(1, c0, c1);
    check("simul_af0", obs_af0, 0);

    // Arbitration order with both VCs backlogged.
    do_init(0, 8, 0, 8);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(6'($urandom_range(0, 63)) & 6'h2F);
      q1.push_back(6'($urandom_range(0, 63)) | 6'h10);
    end
    repeat (12) begin
      cycle();
      if (obs_pop0) seq.push_back(0);
      if (obs_pop1) seq.push_back(1);
    end
`ifdef TX_VC_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    check("arb_len", seq.size(), 8);
    for (int i = 0; i < 8 && i < seq.size(); i++) check("arb_order", seq[i], exp_seq[i]);

    // Randomized traffic, pops, re-inits and occasional mid-run resets.
    for (int n = 0; n < 800; n++) begin
      rst_v = ($urandom_range(0, 299) != 0);
      init_v = ($urandom_range(0, 59) == 0);
      p0_v = ($urandom_range(0, 2) == 0);
      p1_v = ($urandom_range(0, 2) == 0);
      for (int d = 0; d < 2; d++) begin
        lo_v[d] = $urandom_range(0, 6);
        hi_v[d] = $urandom_range(0, 12);
      end
      if (!rst_v) begin q0.delete(); q1.delete(); end
      if (q0.size() < 6 && $urandom_range(0, 1) == 1) q0.push_back(6'($urandom_range(0, 63)));
      if (q1.size() < 6 && $urandom_range(0, 1) == 1) q1.push_back(6'($urandom_range(0, 63)));
      cycle();
    end
    rst_v = 1; init_v = 0; p0_v = 1; p1_v = 1;
    run(20, c0, c1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
